// File: rtl/rs_age_multi_if.sv
// Dispatch, CDB and issue bundle for the age-ordered multi-CDB reservation station.
// The RS uses the slave modport; the dispatch/ALU side uses the master modport.
interface rs_age_multi_if #(
    parameter int DATA_W   = 32,
    parameter int ROB_ID_W = 4,
    parameter int OP_W     = 11,
    parameter int CDB_N    = 2
);
    logic                      disp_valid;
    logic                      disp_ready;
    logic [OP_W-1:0]           disp_op;
    logic                      disp_src1_busy;
    logic [ROB_ID_W-1:0]       disp_src1_tag;
    logic [DATA_W-1:0]         disp_src1_val;
    logic                      disp_src2_busy;
    logic [ROB_ID_W-1:0]       disp_src2_tag;
    logic [DATA_W-1:0]         disp_src2_val;
    logic [ROB_ID_W-1:0]       disp_dest;
    logic [DATA_W-1:0]         disp_imm;
    logic [DATA_W-1:0]         disp_pc;
    logic [CDB_N-1:0]          cdb_valid;
    logic [CDB_N*ROB_ID_W-1:0] cdb_tag;
    logic [CDB_N*DATA_W-1:0]   cdb_data;
    logic                      iss_valid;
    logic                      iss_ready;
    logic [OP_W-1:0]           iss_op;
    logic [DATA_W-1:0]         iss_src1;
    logic [DATA_W-1:0]         iss_src2;
    logic [DATA_W-1:0]         iss_imm;
    logic [DATA_W-1:0]         iss_pc;
    logic [ROB_ID_W-1:0]       iss_dest;

    modport master (
        output disp_valid, disp_op, disp_src1_busy, disp_src1_tag, disp_src1_val,
               disp_src2_busy, disp_src2_tag, disp_src2_val, disp_dest, disp_imm, disp_pc,
               cdb_valid, cdb_tag, cdb_data, iss_ready,
        input  disp_ready, iss_valid, iss_op, iss_src1, iss_src2, iss_imm, iss_pc, iss_dest
    );

    modport slave (
        input  disp_valid, disp_op, disp_src1_busy, disp_src1_tag, disp_src1_val,
               disp_src2_busy, disp_src2_tag, disp_src2_val, disp_dest, disp_imm, disp_pc,
               cdb_valid, cdb_tag, cdb_data, iss_ready,
        output disp_ready, iss_valid, iss_op, iss_src1, iss_src2, iss_imm, iss_pc, iss_dest
    );
endinterface

// File: rtl/rs_age_multi.sv
// Reservation station with multi-channel CDB wakeup and oldest-first issue via an age matrix.
// Optional RS_STAT_EN adds stat_issued / stat_full counters (cleared by rst only).
module rs_age_multi #(
    parameter int RS_DEPTH = 16,
    parameter int DATA_W   = 32,
    parameter int ROB_ID_W = 4,
    parameter int OP_W     = 11,
    parameter int CDB_N    = 2,
    parameter int CNT_W    = $clog2(RS_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    rs_age_multi_if.slave     bus,
`ifdef RS_STAT_EN
    output logic [31:0]       stat_issued,
    output logic [31:0]       stat_full,
`endif
    output logic [CNT_W-1:0]  occupancy
);
    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RS_DEPTH);

    typedef struct packed {
        logic              hit;
        logic [DATA_W-1:0] data;
    } cdb_hit_t;

    // Lowest matching channel wins because lower indices overwrite last.
    function automatic cdb_hit_t cdb_lookup(
        input logic [ROB_ID_W-1:0]       tag,
        input logic [CDB_N-1:0]          vld,
        input logic [CDB_N*ROB_ID_W-1:0] tags,
        input logic [CDB_N*DATA_W-1:0]   data
    );
        cdb_hit_t r;
        r.hit  = 1'b0;
        r.data = {DATA_W{1'b0}};
        for (int c = CDB_N - 1; c >= 0; c--) begin
            if (vld[c] && (tags[c*ROB_ID_W +: ROB_ID_W] == tag)) begin
                r.hit  = 1'b1;
                r.data = data[c*DATA_W +: DATA_W];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    logic [RS_DEPTH-1:0] valid_r, s1_rdy_r, s2_rdy_r;
    logic [ROB_ID_W-1:0] s1_tag_r [RS_DEPTH];
    logic [ROB_ID_W-1:0] s2_tag_r [RS_DEPTH];
    logic [DATA_W-1:0]   s1_val_r [RS_DEPTH];
    logic [DATA_W-1:0]   s2_val_r [RS_DEPTH];
    logic [DATA_W-1:0]   imm_r    [RS_DEPTH];
    logic [DATA_W-1:0]   pc_r     [RS_DEPTH];
    logic [OP_W-1:0]     op_r     [RS_DEPTH];
    logic [ROB_ID_W-1:0] dest_r   [RS_DEPTH];
    // age_r[i][k] = 1 means entry i is younger than entry k
    logic [RS_DEPTH-1:0] age_r    [RS_DEPTH];

    logic [CNT_W-1:0]    occupancy_r;
    logic                iss_valid_r;
    logic [OP_W-1:0]     iss_op_r;
    logic [DATA_W-1:0]   iss_src1_r, iss_src2_r, iss_imm_r, iss_pc_r;
    logic [ROB_ID_W-1:0] iss_dest_r;

    cdb_hit_t            hit1_s [RS_DEPTH];
    cdb_hit_t            hit2_s [RS_DEPTH];
    cdb_hit_t            dhit1_s, dhit2_s;
    logic [RS_DEPTH-1:0] wake1_s, wake2_s, ready_s, oldest_s;
    logic [IDX_W-1:0]    alloc_idx_s, sel_idx_s;
    logic                disp_ready_s, alloc_s, load_s;

    // CDB match for every stored source and for both dispatching sources.
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            hit1_s[i]  = cdb_lookup(s1_tag_r[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            hit2_s[i]  = cdb_lookup(s2_tag_r[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            wake1_s[i] = valid_r[i] & ~s1_rdy_r[i] & hit1_s[i].hit;
            wake2_s[i] = valid_r[i] & ~s2_rdy_r[i] & hit2_s[i].hit;
        end
        dhit1_s = cdb_lookup(bus.disp_src1_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        dhit2_s = cdb_lookup(bus.disp_src2_tag, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
    end

    // Lowest free slot for allocation; oldest ready entry for issue.
    always_comb begin
        alloc_idx_s = {IDX_W{1'b0}};
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!valid_r[i]) begin
                alloc_idx_s = IDX_W'(i);
            end else begin
                alloc_idx_s = alloc_idx_s;
            end
        end
        ready_s   = valid_r & s1_rdy_r & s2_rdy_r;
        sel_idx_s = {IDX_W{1'b0}};
        for (int i = 0; i < RS_DEPTH; i++) begin
            oldest_s[i] = ready_s[i];
            for (int k = 0; k < RS_DEPTH; k++) begin
                oldest_s[i] = oldest_s[i] & ~(ready_s[k] & age_r[i][k]);
            end
            sel_idx_s = sel_idx_s | (oldest_s[i] ? IDX_W'(i) : {IDX_W{1'b0}});
        end
        disp_ready_s = ~rst & rdy & ~rollback & (occupancy_r < DEPTH_C);
        alloc_s      = bus.disp_valid & disp_ready_s;
        load_s       = (|ready_s) & (~iss_valid_r | bus.iss_ready);
    end

    // Entry storage: flush, wakeup capture, issue free and allocation with age update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r  <= {RS_DEPTH{1'b0}};
            s1_rdy_r <= {RS_DEPTH{1'b0}};
            s2_rdy_r <= {RS_DEPTH{1'b0}};
            for (int i = 0; i < RS_DEPTH; i++) begin
                s1_tag_r[i] <= {ROB_ID_W{1'b0}};
                s2_tag_r[i] <= {ROB_ID_W{1'b0}};
                s1_val_r[i] <= {DATA_W{1'b0}};
                s2_val_r[i] <= {DATA_W{1'b0}};
                imm_r[i]    <= {DATA_W{1'b0}};
                pc_r[i]     <= {DATA_W{1'b0}};
                op_r[i]     <= {OP_W{1'b0}};
                dest_r[i]   <= {ROB_ID_W{1'b0}};
                age_r[i]    <= {RS_DEPTH{1'b0}};
            end
        end else if (rdy) begin
            if (rollback) begin
                valid_r <= {RS_DEPTH{1'b0}};
                for (int i = 0; i < RS_DEPTH; i++) begin
                    age_r[i] <= {RS_DEPTH{1'b0}};
                end
            end else begin
                for (int i = 0; i < RS_DEPTH; i++) begin
                    if (wake1_s[i]) begin
                        s1_rdy_r[i] <= 1'b1;
                        s1_val_r[i] <= hit1_s[i].data;
                    end
                    if (wake2_s[i]) begin
                        s2_rdy_r[i] <= 1'b1;
                        s2_val_r[i] <= hit2_s[i].data;
                    end
                end
                if (load_s) begin
                    valid_r[sel_idx_s] <= 1'b0;
                end
                if (alloc_s) begin
                    valid_r[alloc_idx_s]  <= 1'b1;
                    op_r[alloc_idx_s]     <= bus.disp_op;
                    dest_r[alloc_idx_s]   <= bus.disp_dest;
                    imm_r[alloc_idx_s]    <= bus.disp_imm;
                    pc_r[alloc_idx_s]     <= bus.disp_pc;
                    s1_tag_r[alloc_idx_s] <= bus.disp_src1_tag;
                    s2_tag_r[alloc_idx_s] <= bus.disp_src2_tag;
                    s1_rdy_r[alloc_idx_s] <= ~bus.disp_src1_busy | dhit1_s.hit;
                    s2_rdy_r[alloc_idx_s] <= ~bus.disp_src2_busy | dhit2_s.hit;
                    s1_val_r[alloc_idx_s] <= bus.disp_src1_busy ? dhit1_s.data : bus.disp_src1_val;
                    s2_val_r[alloc_idx_s] <= bus.disp_src2_busy ? dhit2_s.data : bus.disp_src2_val;
                    age_r[alloc_idx_s]    <= valid_r;
                    for (int i = 0; i < RS_DEPTH; i++) begin
                        age_r[i][alloc_idx_s] <= 1'b0;
                    end
                end
            end
        end
    end

    // Issue register and occupancy counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid_r <= 1'b0;
            iss_op_r    <= {OP_W{1'b0}};
            iss_src1_r  <= {DATA_W{1'b0}};
            iss_src2_r  <= {DATA_W{1'b0}};
            iss_imm_r   <= {DATA_W{1'b0}};
            iss_pc_r    <= {DATA_W{1'b0}};
            iss_dest_r  <= {ROB_ID_W{1'b0}};
            occupancy_r <= {CNT_W{1'b0}};
        end else if (rdy) begin
            if (rollback) begin
                iss_valid_r <= 1'b0;
                occupancy_r <= {CNT_W{1'b0}};
            end else begin
                occupancy_r <= occupancy_r + CNT_W'(alloc_s) - CNT_W'(load_s);
                if (load_s) begin
                    iss_valid_r <= 1'b1;
                    iss_op_r    <= op_r[sel_idx_s];
                    iss_src1_r  <= s1_val_r[sel_idx_s];
                    iss_src2_r  <= s2_val_r[sel_idx_s];
                    iss_imm_r   <= imm_r[sel_idx_s];
                    iss_pc_r    <= pc_r[sel_idx_s];
                    iss_dest_r  <= dest_r[sel_idx_s];
                end else if (bus.iss_ready) begin
                    iss_valid_r <= 1'b0;
                end
            end
        end
    end

`ifdef RS_STAT_EN
    logic [31:0] stat_issued_r, stat_full_r;

    // Statistics survive rollback; only rst clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued_r <= 32'd0;
            stat_full_r   <= 32'd0;
        end else if (rdy) begin
            stat_issued_r <= stat_issued_r + {31'd0, (~rollback & load_s)};
            stat_full_r   <= stat_full_r + {31'd0, (bus.disp_valid & (occupancy_r == DEPTH_C))};
        end
    end

    assign stat_issued = stat_issued_r;
    assign stat_full   = stat_full_r;
`endif

    assign bus.disp_ready = disp_ready_s;
    assign bus.iss_valid  = iss_valid_r;
    assign bus.iss_op     = iss_op_r;
    assign bus.iss_src1   = iss_src1_r;
    assign bus.iss_src2   = iss_src2_r;
    assign bus.iss_imm    = iss_imm_r;
    assign bus.iss_pc     = iss_pc_r;
    assign bus.iss_dest   = iss_dest_r;
    assign occupancy      = occupancy_r;
endmodule

// File: tb/tb_rs_age_multi.sv
// Directed bench for rs_age_multi: ordering, dispatch bypass, full, back-pressure,
// rollback and asynchronous reset, each with hand-computed expectations.
module tb_rs_age_multi;
    logic       clk = 1'b0;
    logic       rst;
    logic       rdy;
    logic       rollback;
    logic [4:0] occupancy;
    int         tests = 0;
    int         fails = 0;
`ifdef RS_STAT_EN
    logic [31:0] stat_issued, stat_full;
`endif

    rs_age_multi_if bus ();

    rs_age_multi dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .rollback   (rollback),
        .bus        (bus),
`ifdef RS_STAT_EN
        .stat_issued(stat_issued),
        .stat_full  (stat_full),
`endif
        .occupancy  (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic disp(input logic [10:0] op, input logic b1, input logic [3:0] t1,
                        input logic [31:0] v1, input logic b2, input logic [3:0] t2,
                        input logic [31:0] v2, input logic [3:0] dest);
        bus.disp_valid     = 1'b1;
        bus.disp_op        = op;
        bus.disp_src1_busy = b1;
        bus.disp_src1_tag  = t1;
        bus.disp_src1_val  = v1;
        bus.disp_src2_busy = b2;
        bus.disp_src2_tag  = t2;
        bus.disp_src2_val  = v2;
        bus.disp_dest      = dest;
        bus.disp_imm       = {28'h0, dest};
        bus.disp_pc        = 32'h1000 + {21'h0, op};
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
        bus.disp_valid = 1'b0; bus.iss_ready = 1'b0;
        bus.cdb_valid = 2'b00; bus.cdb_tag = 8'h00; bus.cdb_data = 64'h0;
        disp(11'h000, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 4'h0);
        bus.disp_valid = 1'b0;
        #2;
        chk("rst_iss_valid", bus.iss_valid, 1'b0);
        chk("rst_occ", occupancy, 5'd0);
        chk("rst_disp_ready", bus.disp_ready, 1'b0);
        chk("rst_iss_dest", bus.iss_dest, 4'h0);
        step();
        rst = 1'b0;
        #1;
        chk("post_rst_disp_ready", bus.disp_ready, 1'b1);

        // Ordering: A waits on tag 5, B and C are ready
        bus.iss_ready = 1'b1;
        disp(11'h001, 1'b1, 4'd5, 32'h0, 1'b0, 4'd0, 32'h10, 4'd3);
        step();
        disp(11'h002, 1'b0, 4'd0, 32'h20, 1'b0, 4'd0, 32'h21, 4'd4);
        step();
        disp(11'h003, 1'b0, 4'd0, 32'h30, 1'b0, 4'd0, 32'h31, 4'd6);
        step();
        bus.disp_valid = 1'b0;
        chk("ord_B_valid", bus.iss_valid, 1'b1);
        chk("ord_B_dest", bus.iss_dest, 4'd4);
        chk("ord_B_src1", bus.iss_src1, 32'h20);
        chk("ord_occ2", occupancy, 5'd2);
        step();
        chk("ord_C_dest", bus.iss_dest, 4'd6);
        chk("ord_occ1", occupancy, 5'd1);
        bus.cdb_valid = 2'b10; bus.cdb_tag = {4'd5, 4'd0}; bus.cdb_data = {32'h1234, 32'h0};
        step();
        bus.cdb_valid = 2'b00;
        chk("ord_wake_gap", bus.iss_valid, 1'b0);
        step();
        chk("ord_A_valid", bus.iss_valid, 1'b1);
        chk("ord_A_dest", bus.iss_dest, 4'd3);
        chk("ord_A_src1", bus.iss_src1, 32'h1234);
        chk("ord_A_src2", bus.iss_src2, 32'h10);
        chk("ord_A_op", bus.iss_op, 11'h001);
        chk("ord_occ0", occupancy, 5'd0);
        step();
        chk("ord_drain", bus.iss_valid, 1'b0);

        // Dispatch bypass, both channels carry tag 7: channel 0 must win
        disp(11'h004, 1'b0, 4'd0, 32'h5, 1'b1, 4'd7, 32'h0, 4'd9);
        bus.cdb_valid = 2'b11; bus.cdb_tag = {4'd7, 4'd7}; bus.cdb_data = {32'hBEEF, 32'hDEAD};
        step();
        bus.disp_valid = 1'b0; bus.cdb_valid = 2'b00;
        chk("byp_e1_valid", bus.iss_valid, 1'b0);
        chk("byp_occ1", occupancy, 5'd1);
        step();
        chk("byp_valid", bus.iss_valid, 1'b1);
        chk("byp_src2", bus.iss_src2, 32'hDEAD);
        chk("byp_src1", bus.iss_src1, 32'h5);
        chk("byp_dest", bus.iss_dest, 4'd9);
        step();
        chk("byp_drain", bus.iss_valid, 1'b0);

        // rdy=0 blocks dispatch
        rdy = 1'b0;
        disp(11'h005, 1'b0, 4'd0, 32'h1, 1'b0, 4'd0, 32'h2, 4'd1);
        #1;
        chk("rdy0_disp_ready", bus.disp_ready, 1'b0);
        step();
        chk("rdy0_occ", occupancy, 5'd0);
        chk("rdy0_iss_valid", bus.iss_valid, 1'b0);
        rdy = 1'b1; bus.disp_valid = 1'b0;

        // Full: op0 sits in the issue register, ops 1..16 fill the station
        bus.iss_ready = 1'b0;
        for (int k = 0; k < 17; k++) begin
            disp(11'(k + 16), 1'b0, 4'd0, 32'h100 + k, 1'b0, 4'd0, 32'h200 + k, 4'(k));
            step();
        end
        chk("full_occ", occupancy, 5'd16);
        chk("full_disp_ready", bus.disp_ready, 1'b0);
        chk("full_iss_valid", bus.iss_valid, 1'b1);
        disp(11'h7FF, 1'b0, 4'd0, 32'h117, 1'b0, 4'd0, 32'h217, 4'd7);
        for (int c = 0; c < 5; c++) begin
            step();
            chk("bp_src1_hold", bus.iss_src1, 32'h100);
            chk("bp_dest_hold", bus.iss_dest, 4'd0);
            chk("bp_occ_hold", occupancy, 5'd16);
        end
        rdy = 1'b0; bus.iss_ready = 1'b1;
        step();
        chk("freeze_src1", bus.iss_src1, 32'h100);
        chk("freeze_occ", occupancy, 5'd16);
        rdy = 1'b1;
        #1;
        chk("full_same_cycle", bus.disp_ready, 1'b0);
        step();
        chk("bp_next_src1", bus.iss_src1, 32'h101);
        chk("bp_next_dest", bus.iss_dest, 4'd1);
        chk("full_occ15", occupancy, 5'd15);
        chk("full_ready_back", bus.disp_ready, 1'b1);
        bus.iss_ready = 1'b0;
        step();
        chk("refill_occ", occupancy, 5'd16);
        chk("refill_hold", bus.iss_src1, 32'h101);
        bus.disp_valid = 1'b0; bus.iss_ready = 1'b1;
        step();
        chk("age_op2_src1", bus.iss_src1, 32'h102);
        chk("age_occ", occupancy, 5'd15);

        // Rollback beats a simultaneous dispatch
        bus.iss_ready = 1'b0; rollback = 1'b1;
        disp(11'h006, 1'b0, 4'd0, 32'h66, 1'b0, 4'd0, 32'h67, 4'd2);
        #1;
        chk("rb_disp_ready", bus.disp_ready, 1'b0);
        step();
        chk("rb_occ", occupancy, 5'd0);
        chk("rb_iss_valid", bus.iss_valid, 1'b0);
        rollback = 1'b0; bus.disp_valid = 1'b0; bus.iss_ready = 1'b1;
        step();
        chk("rb_no_alloc_valid", bus.iss_valid, 1'b0);
        chk("rb_no_alloc_occ", occupancy, 5'd0);

        // Asynchronous reset between edges
        bus.iss_ready = 1'b0;
        disp(11'h00A, 1'b0, 4'd0, 32'hA, 1'b0, 4'd0, 32'hA, 4'hA);
        step();
        disp(11'h00B, 1'b0, 4'd0, 32'hB, 1'b0, 4'd0, 32'hB, 4'hB);
        step();
        bus.disp_valid = 1'b0;
        chk("ar_pre_valid", bus.iss_valid, 1'b1);
        chk("ar_pre_dest", bus.iss_dest, 4'hA);
        chk("ar_pre_occ", occupancy, 5'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_iss_valid", bus.iss_valid, 1'b0);
        chk("ar_occ", occupancy, 5'd0);
        chk("ar_iss_dest", bus.iss_dest, 4'h0);
        #1;
        rst = 1'b0;
        step();
        chk("ar_after_occ", occupancy, 5'd0);
        chk("ar_after_valid", bus.iss_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
